// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity-type constants and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even type gives XOR of the byte, odd type its complement, so the total
  // number of ones over data plus parity is even or odd respectively.
  function automatic logic parity_bit(input logic [7:0] data, input logic par_typ);
    if (par_typ == PAR_EVEN) begin
      parity_bit = ^data;
    end else begin
      parity_bit = ~^data;
    end
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last
// cycle of each bit and predicts whether the next cycle will be the last one.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_last_nx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;

  // Next count: wrap on bit end, clear on accept or when idle.
  always_comb begin
    o_bit_end = i_en && (r_cnt == LAST);
    if (i_clr || !i_en || o_bit_end) begin
      w_cnt_nx = '0;
    end else begin
      w_cnt_nx = r_cnt + CNT_W'(1);
    end
    o_last_nx = (w_cnt_nx == LAST);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nx;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop
// bit. All outputs are registered and computed from the next-state decode.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  uart_state_e       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_tx_out;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_done;

  uart_state_e       w_state_nx;
  logic [DATA_W-1:0] w_shift_nx;
  logic [IDX_W-1:0]  w_bit_idx_nx;
  logic              w_par_en_nx;
  logic              w_par_bit_nx;
  logic              w_tx_out_nx;
  logic              w_accept;
  logic              w_bit_end;
  logic              w_last_nx;
  logic              w_en;

  assign w_accept = tx_valid && r_tx_ready;
  assign w_en     = (r_state != IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_clr    (w_accept),
    .o_bit_end(w_bit_end),
    .o_last_nx(w_last_nx)
  );

  // Next-state, datapath and line-level decode.
  always_comb begin
    w_state_nx   = r_state;
    w_shift_nx   = r_shift;
    w_bit_idx_nx = r_bit_idx;
    w_par_en_nx  = r_par_en;
    w_par_bit_nx = r_par_bit;
    w_tx_out_nx  = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx   = START;
          w_shift_nx   = tx_data;
          w_bit_idx_nx = '0;
          w_par_en_nx  = par_en;
          w_par_bit_nx = parity_bit(tx_data, par_typ);
        end else begin
          w_state_nx = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
        end else begin
          w_state_nx = START;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nx = r_shift >> 1;
          if (r_bit_idx == IDX_LAST) begin
            w_bit_idx_nx = '0;
            w_state_nx   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_idx_nx = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_state_nx = DATA;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nx = STOP;
        end else begin
          w_state_nx = PARITY;
        end
      end
      STOP: begin
        // Accept in the last stop cycle chains straight into the next start bit.
        if (w_bit_end && w_accept) begin
          w_state_nx   = START;
          w_shift_nx   = tx_data;
          w_bit_idx_nx = '0;
          w_par_en_nx  = par_en;
          w_par_bit_nx = parity_bit(tx_data, par_typ);
        end else if (w_bit_end) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = STOP;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    case (w_state_nx)
      IDLE:    w_tx_out_nx = 1'b1;
      START:   w_tx_out_nx = 1'b0;
      DATA:    w_tx_out_nx = w_shift_nx[0];
      PARITY:  w_tx_out_nx = w_par_bit_nx;
      STOP:    w_tx_out_nx = 1'b1;
      default: w_tx_out_nx = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_par_en   <= w_par_en_nx;
      r_par_bit  <= w_par_bit_nx;
      r_tx_out   <= w_tx_out_nx;
      r_tx_ready <= (w_state_nx == IDLE) || ((w_state_nx == STOP) && w_last_nx);
      r_busy     <= (w_state_nx != IDLE);
      r_done     <= (w_state_nx == STOP) && w_last_nx;
    end
  end

  assign tx_ready = r_tx_ready;
  assign tx_out   = r_tx_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter, the transmit-side counterpart of the team's UART receiver.
- Accepts one byte per valid/ready handshake and serialises it LSB-first as a frame: start bit (0), 8 data bits, optional parity bit, one stop bit (1).
- Parity enable and parity type follow the same par_en/par_typ convention as the receiver, so TX and RX pair directly on the serial line.

Parameters:
DATA_W, 8, payload bits per frame (fixed at 8 for this project; any other value is unsupported)
CLKS_PER_BIT, 16, clk cycles each serial bit is held on tx_out (legal range 1..65535)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
par_en  in  1  1 = append parity bit; sampled at byte acceptance
par_typ  in  1  0 = even parity, 1 = odd parity; sampled at byte acceptance
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  block can accept a byte this cycle
tx_out  out  1  serial line, idle high
busy  out  1  frame in progress (any state other than IDLE)
done  out  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: tx_out=1, tx_ready=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Asynchronous reset mid-frame aborts the frame; tx_out returns to 1 immediately, with no partial stop bit.
- Handshake:
  - Accept when tx_valid && tx_ready on a rising clk edge.
  - tx_ready = (state==IDLE) || (state==STOP && baud counter==CLKS_PER_BIT-1).
  - At acceptance, tx_data, par_en and par_typ are latched. Later input changes do not affect the frame in flight.
- Parity:
  - Parity bit is computed from the latched byte: even gives ^data, odd gives ~^data.
  - Total ones over data+parity is even (par_typ=0) or odd (par_typ=1).
- States:
  - IDLE: tx_out=1. On accept, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out=shift[0]. Shift right every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if the latched par_en=1, else go to STOP.
  - PARITY: tx_out=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 on the last cycle. Next state is START if a byte is accepted that cycle, else IDLE.
- Timing:
  - tx_out is registered. The start bit appears on the first clk edge after acceptance, so latency is 1 cycle.
  - Frame length is 10×CLKS_PER_BIT cycles without parity and 11×CLKS_PER_BIT with parity.
  - Back-to-back acceptance in the last stop cycle gives a gap-free next start bit (no extra idle cycle).
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), minimum 1.
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary and on accept.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Ignored inputs: tx_valid while tx_ready=0 is ignored. The byte is not queued, and the source must hold it.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, START, DATA, PARITY, STOP
  - parity-type constants: PAR_EVEN=0, PAR_ODD=1
  - the shared parity function, also used by the receiver
- One natural sub-module, uart_baud_cnt: parameterised bit-period counter with a bit_end output. It is reusable by the receiver's oversampler.

Test Plan:
1. CLKS_PER_BIT=4, par_en=0, send 0xA5 → tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; done at cycle 40 after accept; tx_ready high the same cycle.
2. par_en=1, par_typ=0, 0xA5 → parity bit 0, 11-bit frame. Then par_typ=1 with 0x01 → parity bit 0; par_typ=0 with 0x01 → parity bit 1.
3. tx_valid held high with 0x3C then 0xC3 → second start bit immediately follows the first stop bit; tx_out never high longer than one bit between frames.
4. Assert rst during data bit 3 → tx_out=1, busy=0, tx_ready=1 asynchronously. After release, a new byte 0xFF transmits a correct full frame.
5. Change tx_data, par_en and par_typ mid-frame → serialised bits and parity match the values latched at acceptance.
6. CLKS_PER_BIT=1, 0x00 with odd parity → tx_out: 0,0,0,0,0,0,0,0,0,1,1; done on cycle 11.
